// File: rtl/stripe_tx_pkg.sv
// Shared constants and phase encoding for the stripe_tx / unstripe lane pair.
// The phase names tell which lane register may change at the upcoming edge.
package stripe_tx_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    typedef enum logic {
        PH_LANE0 = 1'b0,
        PH_LANE1 = 1'b1
    } phase_t;

endpackage

// File: rtl/stripe_tx_if.sv
// Word-stream input and two-lane output bundle of the striper.
// master = upstream source / downstream sink side, slave = stripe_tx.
interface stripe_tx_if
    import stripe_tx_pkg::*;
#(
    parameter int DATA_W = stripe_tx_pkg::DATA_W
);

    logic [DATA_W-1:0] dataIn;
    logic              validIn;
    logic              readyOut;
    logic              flush;
    logic [DATA_W-1:0] lane0;
    logic [DATA_W-1:0] lane1;
    logic              valid0;
    logic              valid1;

    modport master (
        output dataIn, validIn, flush,
        input  readyOut, lane0, lane1, valid0, valid1
    );

    modport slave (
        input  dataIn, validIn, flush,
        output readyOut, lane0, lane1, valid0, valid1
    );

endinterface

// File: rtl/stripe_fifo.sv
// Small FIFO with one write port and a dual-head read (oldest two entries),
// able to retire one or two entries per cycle.
module stripe_fifo
    import stripe_tx_pkg::*;
#(
    parameter  int DATA_W = stripe_tx_pkg::DATA_W,
    parameter  int DEPTH  = stripe_tx_pkg::DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop1,
    input  logic              pop2,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CNT_W-1:0]  pop_n;

    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    always_comb begin
        pop_n       = pop2 ? CNT_W'(2) : (pop1 ? CNT_W'(1) : '0);
        wr_ptr_next = wr_ptr_reg + PTR_W'(push);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop_n);
        count_next  = count_reg + CNT_W'(push) - pop_n;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign rd0   = mem[rd_ptr_reg];
    assign rd1   = mem[rd_ptr_reg + PTR_W'(1)];
    assign count = count_reg;

endmodule

// File: rtl/stripe_tx.sv
// Lane striper: even words leave on lane0 at phase-0 edges, their odd partners
// on lane1 one cycle later; each lane word is held for two cycles.
module stripe_tx
    import stripe_tx_pkg::*;
#(
    parameter int DATA_W = stripe_tx_pkg::DATA_W,
    parameter int DEPTH  = stripe_tx_pkg::DEPTH
) (
    input  logic        clk_2f,
    input  logic        reset,
    stripe_tx_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rd0, rd1;
    logic              ready, push;
    logic              pair_issue, flush_issue;

    phase_t            phase_reg, phase_next;
    logic [DATA_W-1:0] lane0_reg, lane0_next;
    logic [DATA_W-1:0] lane1_reg, lane1_next;
    logic [DATA_W-1:0] pend_reg, pend_next;
    logic              valid0_reg, valid0_next;
    logic              valid1_reg, valid1_next;
    logic              pend_v_reg, pend_v_next;

    assign ready = (count < CNT_W'(DEPTH));
    assign push  = bus.validIn && ready;

    stripe_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk_2f),
        .srst  (reset),
        .push  (push),
        .wdata (bus.dataIn),
        .pop1  (flush_issue),
        .pop2  (pair_issue),
        .rd0   (rd0),
        .rd1   (rd1),
        .count (count)
    );

    always_comb begin
        phase_next  = (phase_reg == PH_LANE0) ? PH_LANE1 : PH_LANE0;
        lane0_next  = lane0_reg;
        valid0_next = valid0_reg;
        lane1_next  = lane1_reg;
        valid1_next = valid1_reg;
        pend_next   = pend_reg;
        pend_v_next = pend_v_reg;
        pair_issue  = 1'b0;
        flush_issue = 1'b0;

        if (phase_reg == PH_LANE0) begin
            // Pops see only the pre-edge occupancy; a same-edge push lands behind them.
            if (count >= CNT_W'(2)) begin
                pair_issue  = 1'b1;
                lane0_next  = rd0;
                valid0_next = 1'b1;
                pend_next   = rd1;
                pend_v_next = 1'b1;
            end else if (count == CNT_W'(1) && bus.flush) begin
                flush_issue = 1'b1;
                lane0_next  = rd0;
                valid0_next = 1'b1;
                pend_v_next = 1'b0;
            end else begin
                lane0_next  = '0;
                valid0_next = 1'b0;
                pend_v_next = 1'b0;
            end
        end else begin
            lane1_next  = pend_v_reg ? pend_reg : '0;
            valid1_next = pend_v_reg;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            phase_reg  <= PH_LANE0;
            lane0_reg  <= '0;
            valid0_reg <= 1'b0;
            lane1_reg  <= '0;
            valid1_reg <= 1'b0;
            pend_reg   <= '0;
            pend_v_reg <= 1'b0;
        end else begin
            phase_reg  <= phase_next;
            lane0_reg  <= lane0_next;
            valid0_reg <= valid0_next;
            lane1_reg  <= lane1_next;
            valid1_reg <= valid1_next;
            pend_reg   <= pend_next;
            pend_v_reg <= pend_v_next;
        end
    end

    assign bus.readyOut = ready;
    assign bus.lane0    = lane0_reg;
    assign bus.valid0   = valid0_reg;
    assign bus.lane1    = lane1_reg;
    assign bus.valid1   = valid1_reg;

endmodule

// File: tb/tb_stripe_tx.sv
// Bench for stripe_tx: vector tables, directed corner sequences and a random
// run checked against a queue-based reference model.
module tb_stripe_tx;
    import stripe_tx_pkg::*;

    localparam int DEP4 = 4;
    localparam int DEP2 = 2;

    logic clk_2f = 1'b0;
    logic reset  = 1'b1;
    always #5 clk_2f = ~clk_2f;

    stripe_tx_if #(.DATA_W(32)) bus4 ();
    stripe_tx_if #(.DATA_W(32)) bus2 ();

    stripe_tx #(.DATA_W(32), .DEPTH(DEP4)) dut4 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus4)
    );

    stripe_tx #(.DATA_W(32), .DEPTH(DEP2)) dut2 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus2)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] d;
        logic        f;
        logic        rdy;
        logic [31:0] l0;
        logic        v0;
        logic [31:0] l1;
        logic        v1;
    } row_t;

    row_t tab4 [22];
    row_t tab2 [13];

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO as a queue, phase as edge parity since reset.
    logic [31:0] mq [$];
    bit          mph;
    logic [31:0] m_l0, m_l1, m_pd;
    bit          m_v0, m_v1, m_pv;

    function automatic row_t mk(input logic r, input logic v, input logic [31:0] d,
                                input logic f, input logic rdy,
                                input logic [31:0] l0, input logic v0,
                                input logic [31:0] l1, input logic v1);
        row_t x;
        x.r = r; x.v = v; x.d = d; x.f = f; x.rdy = rdy;
        x.l0 = l0; x.v0 = v0; x.l1 = l1; x.v1 = v1;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] d,
                        input logic f, output logic rdy_pre);
        bit acc;
        @(negedge clk_2f);
        reset         = r;
        bus4.validIn  = v;
        bus4.dataIn   = d;
        bus4.flush    = f;
        bus2.validIn  = 1'b0;
        bus2.dataIn   = '0;
        bus2.flush    = 1'b0;
        #1;
        rdy_pre = bus4.readyOut;
        if (!r) chk("model_ready", 32'(bus4.readyOut), 32'(mq.size() < DEP4));
        acc = v && (mq.size() < DEP4);
        @(posedge clk_2f);
        if (r) begin
            mq.delete();
            mph = 1'b0;
            m_l0 = '0; m_l1 = '0; m_pd = '0;
            m_v0 = 1'b0; m_v1 = 1'b0; m_pv = 1'b0;
        end else begin
            if (!mph) begin
                if (mq.size() >= 2) begin
                    m_l0 = mq.pop_front(); m_v0 = 1'b1;
                    m_pd = mq.pop_front(); m_pv = 1'b1;
                end else if (mq.size() == 1 && f) begin
                    m_l0 = mq.pop_front(); m_v0 = 1'b1; m_pv = 1'b0;
                end else begin
                    m_l0 = '0; m_v0 = 1'b0; m_pv = 1'b0;
                end
            end else begin
                m_l1 = m_pv ? m_pd : '0;
                m_v1 = m_pv;
            end
            if (acc) mq.push_back(d);
            mph = ~mph;
        end
        #1;
        chk("model_lane0",  bus4.lane0, m_l0);
        chk("model_valid0", 32'(bus4.valid0), 32'(m_v0));
        chk("model_lane1",  bus4.lane1, m_l1);
        chk("model_valid1", 32'(bus4.valid1), 32'(m_v1));
    endtask

    task automatic step0(input logic r, input logic v, input logic [31:0] d, input logic f);
        logic dummy;
        step(r, v, d, f, dummy);
    endtask

    task automatic apply4(input int i);
        logic rdy_pre;
        step(tab4[i].r, tab4[i].v, tab4[i].d, tab4[i].f, rdy_pre);
        if (!tab4[i].r) chk($sformatf("t4[%0d].ready", i), 32'(rdy_pre), 32'(tab4[i].rdy));
        chk($sformatf("t4[%0d].lane0", i),  bus4.lane0, tab4[i].l0);
        chk($sformatf("t4[%0d].valid0", i), 32'(bus4.valid0), 32'(tab4[i].v0));
        chk($sformatf("t4[%0d].lane1", i),  bus4.lane1, tab4[i].l1);
        chk($sformatf("t4[%0d].valid1", i), 32'(bus4.valid1), 32'(tab4[i].v1));
        $display("t4 row %0d: in v=%b d=%h f=%b -> lane0=%h/%b lane1=%h/%b", i,
                 tab4[i].v, tab4[i].d, tab4[i].f, bus4.lane0, bus4.valid0, bus4.lane1, bus4.valid1);
    endtask

    task automatic apply2(input int i);
        logic rdy_pre;
        @(negedge clk_2f);
        reset        = tab2[i].r;
        bus2.validIn = tab2[i].v;
        bus2.dataIn  = tab2[i].d;
        bus2.flush   = tab2[i].f;
        bus4.validIn = 1'b0;
        bus4.flush   = 1'b0;
        #1;
        rdy_pre = bus2.readyOut;
        @(posedge clk_2f);
        #1;
        if (!tab2[i].r) chk($sformatf("t2[%0d].ready", i), 32'(rdy_pre), 32'(tab2[i].rdy));
        chk($sformatf("t2[%0d].lane0", i),  bus2.lane0, tab2[i].l0);
        chk($sformatf("t2[%0d].valid0", i), 32'(bus2.valid0), 32'(tab2[i].v0));
        chk($sformatf("t2[%0d].lane1", i),  bus2.lane1, tab2[i].l1);
        chk($sformatf("t2[%0d].valid1", i), 32'(bus2.valid1), 32'(tab2[i].v1));
        $display("t2 row %0d: in v=%b d=%h f=%b ready=%b -> lane0=%h/%b lane1=%h/%b", i,
                 tab2[i].v, tab2[i].d, tab2[i].f, rdy_pre, bus2.lane0, bus2.valid0, bus2.lane1, bus2.valid1);
    endtask

    initial begin
        logic [31:0] cur_d;
        logic        cur_v, cur_f, cur_r;

        bus4.validIn = 1'b0; bus4.dataIn = '0; bus4.flush = 1'b0;
        bus2.validIn = 1'b0; bus2.dataIn = '0; bus2.flush = 1'b0;
        mph = 1'b0; m_l0 = '0; m_l1 = '0; m_pd = '0;
        m_v0 = 1'b0; m_v1 = 1'b0; m_pv = 1'b0;

        // Continuous stream A0..A7, then odd tail B0..B2 with a late flush (DEPTH 4).
        tab4[0]  = mk(1, 0, 32'h0,  0, 1, 32'h0,  0, 32'h0,  0);
        tab4[1]  = mk(0, 1, 32'hA0, 0, 1, 32'h0,  0, 32'h0,  0);
        tab4[2]  = mk(0, 1, 32'hA1, 0, 1, 32'h0,  0, 32'h0,  0);
        tab4[3]  = mk(0, 1, 32'hA2, 0, 1, 32'hA0, 1, 32'h0,  0);
        tab4[4]  = mk(0, 1, 32'hA3, 0, 1, 32'hA0, 1, 32'hA1, 1);
        tab4[5]  = mk(0, 1, 32'hA4, 0, 1, 32'hA2, 1, 32'hA1, 1);
        tab4[6]  = mk(0, 1, 32'hA5, 0, 1, 32'hA2, 1, 32'hA3, 1);
        tab4[7]  = mk(0, 1, 32'hA6, 0, 1, 32'hA4, 1, 32'hA3, 1);
        tab4[8]  = mk(0, 1, 32'hA7, 0, 1, 32'hA4, 1, 32'hA5, 1);
        tab4[9]  = mk(0, 0, 32'h0,  0, 1, 32'hA6, 1, 32'hA5, 1);
        tab4[10] = mk(0, 0, 32'h0,  0, 1, 32'hA6, 1, 32'hA7, 1);
        tab4[11] = mk(0, 0, 32'h0,  0, 1, 32'h0,  0, 32'hA7, 1);
        tab4[12] = mk(0, 0, 32'h0,  0, 1, 32'h0,  0, 32'h0,  0);
        tab4[13] = mk(0, 1, 32'hB0, 0, 1, 32'h0,  0, 32'h0,  0);
        tab4[14] = mk(0, 1, 32'hB1, 0, 1, 32'h0,  0, 32'h0,  0);
        tab4[15] = mk(0, 1, 32'hB2, 0, 1, 32'hB0, 1, 32'h0,  0);
        tab4[16] = mk(0, 0, 32'h0,  0, 1, 32'hB0, 1, 32'hB1, 1);
        tab4[17] = mk(0, 0, 32'h0,  0, 1, 32'h0,  0, 32'hB1, 1);
        tab4[18] = mk(0, 0, 32'h0,  0, 1, 32'h0,  0, 32'h0,  0);
        tab4[19] = mk(0, 0, 32'h0,  1, 1, 32'hB2, 1, 32'h0,  0);
        tab4[20] = mk(0, 0, 32'h0,  0, 1, 32'hB2, 1, 32'h0,  0);
        tab4[21] = mk(0, 0, 32'h0,  0, 1, 32'h0,  0, 32'h0,  0);

        // Backpressure on a 2-entry FIFO: held words wait for readyOut, none lost or doubled.
        tab2[0]  = mk(1, 0, 32'h0,  0, 1, 32'h0,  0, 32'h0,  0);
        tab2[1]  = mk(0, 1, 32'hD0, 0, 1, 32'h0,  0, 32'h0,  0);
        tab2[2]  = mk(0, 1, 32'hD1, 0, 1, 32'h0,  0, 32'h0,  0);
        tab2[3]  = mk(0, 1, 32'hD2, 0, 0, 32'hD0, 1, 32'h0,  0);
        tab2[4]  = mk(0, 1, 32'hD2, 0, 1, 32'hD0, 1, 32'hD1, 1);
        tab2[5]  = mk(0, 1, 32'hD3, 0, 1, 32'h0,  0, 32'hD1, 1);
        tab2[6]  = mk(0, 1, 32'hD4, 0, 0, 32'h0,  0, 32'h0,  0);
        tab2[7]  = mk(0, 1, 32'hD4, 0, 0, 32'hD2, 1, 32'h0,  0);
        tab2[8]  = mk(0, 1, 32'hD4, 0, 1, 32'hD2, 1, 32'hD3, 1);
        tab2[9]  = mk(0, 0, 32'h0,  0, 1, 32'h0,  0, 32'hD3, 1);
        tab2[10] = mk(0, 0, 32'h0,  0, 1, 32'h0,  0, 32'h0,  0);
        tab2[11] = mk(0, 0, 32'h0,  1, 1, 32'hD4, 1, 32'h0,  0);
        tab2[12] = mk(0, 0, 32'h0,  0, 1, 32'hD4, 1, 32'h0,  0);

        for (int i = 0; i < 13; i++) apply2(i);
        for (int i = 0; i < 22; i++) apply4(i);

        // Misaligned start: first push on a phase-1 edge.
        step0(1, 0, 32'h0, 0);
        step0(0, 0, 32'h0, 0);
        step0(0, 1, 32'h5A0, 0);
        step0(0, 1, 32'h5A1, 0);
        step0(0, 0, 32'h0, 0);
        step0(0, 0, 32'h0, 0);
        chk("misaligned_lane0", bus4.lane0, 32'h5A0);
        chk("misaligned_valid0", 32'(bus4.valid0), 32'd1);
        step0(0, 0, 32'h0, 0);
        chk("misaligned_lane1", bus4.lane1, 32'h5A1);
        $display("misaligned start: lane0=%h lane1=%h", bus4.lane0, bus4.lane1);

        // Reset right after lane0 issues C0: C1 must never appear.
        step0(1, 0, 32'h0, 0);
        step0(0, 1, 32'hC0, 0);
        step0(0, 1, 32'hC1, 0);
        step0(0, 0, 32'h0, 0);
        chk("midpair_lane0", bus4.lane0, 32'hC0);
        step0(1, 0, 32'h0, 0);
        chk("rst_lane0", bus4.lane0, 32'h0);
        chk("rst_valid0", 32'(bus4.valid0), 32'd0);
        chk("rst_lane1", bus4.lane1, 32'h0);
        chk("rst_valid1", 32'(bus4.valid1), 32'd0);
        chk("rst_ready", 32'(bus4.readyOut), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step0(0, 0, 32'h0, 0);
            chk("post_rst_valid1", 32'(bus4.valid1), 32'd0);
            chk("post_rst_lane1", bus4.lane1, 32'h0);
        end
        $display("reset mid-pair: outputs cleared, lane1=%h", bus4.lane1);

        // Push during pair issue, and pointer wrap over 3*DEPTH words.
        step0(1, 0, 32'h0, 0);
        for (int k = 0; k < 3 * DEP4 + 2; k++) step0(0, 1, 32'hE00 + 32'(k), 0);
        for (int k = 0; k < 6; k++) step0(0, 0, 32'h0, 1);
        $display("wrap sequence: %0d words streamed", 3 * DEP4 + 2);

        // Random traffic; an unaccepted word is held until taken.
        step0(1, 0, 32'h0, 0);
        cur_v = 1'b0; cur_d = '0;
        for (int n = 0; n < 3000; n++) begin
            cur_r = ($urandom_range(0, 199) == 0);
            if (!cur_v) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = $urandom;
            end
            cur_f = ($urandom_range(0, 3) == 0);
            if (cur_r || (cur_v && mq.size() < DEP4) || !cur_v) begin
                step0(cur_r, cur_v, cur_d, cur_f);
                cur_v = 1'b0;
            end else begin
                step0(cur_r, cur_v, cur_d, cur_f);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stripe_tx.md
# stripe_tx

Transmit-side lane striper feeding `unstripe` directly. Accepts a single 32-bit word stream under a valid/ready handshake and distributes words alternately onto lane0 (even words) and lane1 (odd words). Each lane word is held for two `clk_2f` cycles, with lane1 staggered one cycle behind lane0, so the downstream merger sees lane0, lane1, lane0, … on successive cycles. A small FIFO absorbs bursty input so that words always leave as ordered even/odd pairs.

## Interface
- `DATA_W`, 32: word width.
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk_2f`  in  1: single clock (2f rate); all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `dataIn`  in  DATA_W: input word.
- `validIn`  in  1: `dataIn` valid.
- `readyOut`  out  1: FIFO can accept; combinational, equals `count < DEPTH`.
- `flush`  in  1: force a lone leftover word out without its pair.
- `lane0`  out  DATA_W: even-word lane, registered.
- `lane1`  out  DATA_W: odd-word lane, registered.
- `valid0`  out  1: lane0 valid, registered.
- `valid1`  out  1: lane1 valid, registered.

## Operation
- **Push:** `validIn && readyOut` at an edge writes `dataIn` at `wr_ptr`. Pointers wrap modulo `DEPTH`. `count` is (0..DEPTH) wide.
- **Phase:** `phase` toggles every edge; it is 0 in the first cycle after reset. A "phase-0 edge" is one where the sampled `phase` is 0.
- **Phase-0 edge, pair issue:** if `count >= 2` (pre-push value):
  - `lane0 <= mem[rd]`, `valid0 <= 1`
  - `pend <= mem[rd+1]`, `pend_v <= 1`
  - `rd_ptr += 2`, `count -= 2`
- **Phase-0 edge, flush issue:** else if `count == 1 && flush`:
  - `lane0 <= mem[rd]`, `valid0 <= 1`, `pend_v <= 0`
  - `rd_ptr += 1`, `count -= 1`
- **Phase-0 edge, idle:** otherwise `lane0 <= 0`, `valid0 <= 0`, `pend_v <= 0`.
- **Phase-1 edge:** `lane1 <= pend_v ? pend : 0`, `valid1 <= pend_v`. `lane0`/`valid0` hold.
- **Lane1 outside phase-1 edges:** `lane1`/`valid1` hold.
- **Count update:** `count <= count + push - popN`. Push and pop in the same edge are legal. Pop reads use pre-edge FIFO contents only.
- **Full FIFO:** `readyOut = 0`; input is not accepted. An upstream that presents `validIn` without `readyOut` must hold its word.
- **Lone leftover word, no `flush`:** waits indefinitely for its partner word.
- **Invalid lanes:** always drive data 0.
- **Reset mid-operation:** all buffered and pending words are discarded. No partial pair is emitted after reset.

## Timing
- **Reset values:** `lane0 = lane1 = 0`, `valid0 = valid1 = 0`, `readyOut = 1`. Internal state `phase = 0`, `count = 0`, `wr_ptr = rd_ptr = 0`, `pend_v = 0`.
- **Hold times:** lane0 changes only at phase-0 edges and lane1 only at phase-1 edges, so each holds 2 cycles. lane1 lags lane0 by exactly 1 cycle.
- **Latency, first word pushed at a phase-0 edge (partner at next edge):** lane0 valid 2 cycles after the first push; lane1 valid 3 cycles after.
- **Latency, first word pushed at a phase-1 edge:** 3 cycles to lane0.
- **Throughput:** one word per cycle sustained, with a 2-entry FIFO occupancy in steady state. `readyOut` never drops for continuous input when `DEPTH ≥ 4`.

## Structure
- **Shared package:** `DATA_W`, default `DEPTH`, and the phase encoding (`PH_LANE0 = 0`, `PH_LANE1 = 1`), shared with `unstripe`'s bench.
- **Sub-module `stripe_fifo`:**
  - synchronous write port; dual-head read of `mem[rd]` and `mem[rd+1]`
  - `pop1`/`pop2` inputs; `count` output
- **Top level:** phase, pair/flush decision, pend register, output registers.

## Test plan
- **Continuous stream:** reset, then push 0xA0..0xA7 from the first phase-0 edge → lane0 shows A0, A2, A4, A6 and lane1 shows A1, A3, A5, A7, each 2 cycles. `valid0`/`valid1` stay high from first assertion through the last pair. Looping into `unstripe` reproduces A0..A7 in order.
- **Misaligned start:** first push at a phase-1 edge → lane0 = A0 3 cycles later, lane1 = A1 one cycle after that.
- **Odd tail:** push three words B0..B2, no `flush` → only the B0/B1 pair emitted; B2 held and `count == 1`. Assert `flush` at the next phase-0 edge → lane0 = B2 with `valid0 = 1`, and `valid1 = 0`, `lane1 = 0` at the following phase-1 edge.
- **Backpressure:** stall issue by pushing only at phase-1 edges until `count == DEPTH` → `readyOut = 0`, and a held `validIn` word is not written. It is accepted after the next pair issue; no loss or duplication.
- **Reset mid-pair:** assert reset the cycle after lane0 issues C0 → next cycle all outputs 0, `readyOut = 1`, C1 never appears on lane1.
- **Simultaneous push and pop:** at `count == 2`, push at a phase-0 edge → the pair issues and `count` becomes 1. The pointers wrap correctly across 3×`DEPTH` words with in-order output.
